ball_position_tracker: RTL and testbench

BALL_POSITION_TRACKER -- requirements
Module: ball_position_tracker

---
 rtl/ball_pkg.sv | 37 +++
 rtl/ball_position_tracker.sv | 147 ++++++++++++++
 tb/tb_ball_position_tracker.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Ball tracker shared definitions: map cell codes,
// move pulse bit positions, FSM states, axis step helper.
package ball_pkg;

  localparam logic [1:0] CELL_OPEN = 2'b00;
  localparam logic [1:0] CELL_WALL = 2'b01;
  localparam logic [1:0] CELL_HOLE = 2'b10;
  localparam logic [1:0] CELL_GOAL = 2'b11;

  localparam int MV_X_INC = 3;
  localparam int MV_X_DEC = 2;
  localparam int MV_Y_INC = 1;
  localparam int MV_Y_DEC = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] pos;
  } step_t;

  // One-cell step along an axis; hit flags a move off the grid.
  function automatic step_t step(
    input logic [3:0] p,
    input logic       inc
  );
    step_t s;
    s.hit = inc ? (p == 4'hF) : (p == 4'h0);
    s.pos = inc ? p + 4'd1 : p - 4'd1;
    return s;
  endfunction

endpackage

// File: rtl/ball_position_tracker.sv
// Ball position tracker: resolves move pulses against an
// external 1-cycle-latency map ROM, X axis before Y axis.
module ball_position_tracker
  import ball_pkg::*;
#(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] move_pulses,
  output logic       map_rd,
  output logic [7:0] map_addr,
  input  logic [1:0] map_data,
  output logic [3:0] x_pos,
  output logic [3:0] y_pos,
  output logic       busy,
  output logic       blocked,
  output logic       fell,
  output logic       won,
  output logic [7:0] drop_cnt
);

  state_t     state;
  logic       pend_y;
  logic       dir_y;
  logic       at_edge;
  logic [3:0] tgt_x;
  logic [3:0] tgt_y;

  logic       x_go;
  logic       y_go;
  logic       any_req;
  step_t      sx;
  step_t      sy;
  step_t      sy_next;
  logic [3:0] nx;
  logic       stop;
  logic       y_next;

  assign x_go = move_pulses[MV_X_INC]
              ^ move_pulses[MV_X_DEC];
  assign y_go = move_pulses[MV_Y_INC]
              ^ move_pulses[MV_Y_DEC];
  assign any_req = |move_pulses;

  assign sx = step(x_pos, move_pulses[MV_X_INC]);
  assign sy = step(y_pos, move_pulses[MV_Y_INC]);
  assign sy_next = step(y_pos, dir_y);

  // Y leg starts from the X-updated column; hole/goal end the move.
  assign nx = (!at_edge && map_data == CELL_OPEN)
            ? tgt_x : x_pos;
  assign stop = !at_edge && map_data[1];
  assign y_next = pend_y && !stop;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      x_pos    <= START_X;
      y_pos    <= START_Y;
      pend_y   <= 1'b0;
      dir_y    <= 1'b0;
      at_edge  <= 1'b0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      map_rd   <= 1'b0;
      map_addr <= '0;
      blocked  <= 1'b0;
      fell     <= 1'b0;
      won      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      map_rd  <= 1'b0;
      blocked <= 1'b0;
      fell    <= 1'b0;
      if (busy && !won && any_req
          && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      unique case (state)
        S_IDLE: begin
          if (!won && (x_go || y_go)) begin
            state  <= S_READ;
            pend_y <= x_go && y_go;
            dir_y  <= move_pulses[MV_Y_INC];
            if (x_go) begin
              tgt_x   <= sx.pos;
              tgt_y   <= y_pos;
              at_edge <= sx.hit;
              map_rd  <= !sx.hit;
              if (!sx.hit)
                map_addr <= {y_pos, sx.pos};
            end else begin
              tgt_x   <= x_pos;
              tgt_y   <= sy.pos;
              at_edge <= sy.hit;
              map_rd  <= !sy.hit;
              if (!sy.hit)
                map_addr <= {sy.pos, x_pos};
            end
          end
        end
        S_READ: begin
          blocked <= at_edge;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (!at_edge) begin
            unique case (map_data)
              CELL_OPEN: begin
                x_pos <= tgt_x;
                y_pos <= tgt_y;
              end
              CELL_WALL: blocked <= 1'b1;
              CELL_HOLE: begin
                x_pos <= START_X;
                y_pos <= START_Y;
                fell  <= 1'b1;
              end
              CELL_GOAL: begin
                x_pos <= tgt_x;
                y_pos <= tgt_y;
                won   <= 1'b1;
              end
            endcase
          end
          pend_y <= 1'b0;
          if (y_next) begin
            state   <= S_READ;
            tgt_x   <= nx;
            tgt_y   <= sy_next.pos;
            at_edge <= sy_next.hit;
            map_rd  <= !sy_next.hit;
            if (!sy_next.hit)
              map_addr <= {sy_next.pos, nx};
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_position_tracker.sv
// Bench for ball_position_tracker: transaction-level model
// scheduling per-cycle expectations, directed plus random moves.
module tb_ball_position_tracker;
  import ball_pkg::*;

  localparam logic [3:0] SX = 4'd1;
  localparam logic [3:0] SY = 4'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] move_pulses = '0;
  logic       map_rd;
  logic [7:0] map_addr;
  logic [1:0] map_data = '0;
  logic [3:0] x_pos;
  logic [3:0] y_pos;
  logic       busy;
  logic       blocked;
  logic       fell;
  logic       won;
  logic [7:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] mem [256];

  always #5 clk = ~clk;

  ball_position_tracker #(
    .START_X(SX),
    .START_Y(SY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .move_pulses(move_pulses),
    .map_rd(map_rd),
    .map_addr(map_addr),
    .map_data(map_data),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .busy(busy),
    .blocked(blocked),
    .fell(fell),
    .won(won),
    .drop_cnt(drop_cnt)
  );

  // External map ROM, one cycle of read latency
  always @(posedge clk)
    if (map_rd) map_data <= mem[map_addr];

  typedef struct {
    logic       rd;
    logic [7:0] addr;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       blk;
    logic       fell;
    logic       won;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   mx;
  int   my;
  logic mwon;
  int   mdrop;
  bit   started = 0;

  function automatic exp_t rec(
    input bit rd, input int addr,
    input int x, input int y,
    input bit bz, input bit blk,
    input bit fl, input bit w
  );
    exp_t r;
    r.rd = rd;
    r.addr = addr[7:0];
    r.x = x[3:0];
    r.y = y[3:0];
    r.busy = bz;
    r.blk = blk;
    r.fell = fl;
    r.won = w;
    return r;
  endfunction

  // Whole move resolved up front: each axis leg is a read cycle
  // and a check cycle; its effect shows in the cycle after.
  task automatic plan(input logic [3:0] p);
    int cx, cy, tx, ty;
    bit w, cb, cf, go_y, hit, xv, yv;
    xv = p[3] != p[2];
    yv = p[1] != p[0];
    if (!xv && !yv) return;
    cx = mx; cy = my;
    w = 0; cb = 0; cf = 0; go_y = yv;
    for (int ax = 0; ax < 2; ax++) begin
      if (ax == 0 && !xv) continue;
      if (ax == 1 && !go_y) continue;
      tx = cx; ty = cy;
      if (ax == 0) tx = p[3] ? cx + 1 : cx - 1;
      else ty = p[1] ? cy + 1 : cy - 1;
      hit = tx < 0 || tx > 15 || ty < 0 || ty > 15;
      q.push_back(rec(!hit, ty * 16 + tx, cx, cy,
                      1, cb, cf, 0));
      cb = 0; cf = 0;
      q.push_back(rec(0, 0, cx, cy, 1, hit, 0, 0));
      if (!hit) begin
        case (mem[ty * 16 + tx])
          CELL_OPEN: begin cx = tx; cy = ty; end
          CELL_WALL: cb = 1;
          CELL_HOLE: begin
            cx = SX; cy = SY; cf = 1; go_y = 0;
          end
          default: begin
            cx = tx; cy = ty; w = 1; go_y = 0;
          end
        endcase
      end
    end
    q.push_back(rec(0, 0, cx, cy, 0, cb, cf, w));
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      mx = SX; my = SY;
      mwon = 0; mdrop = 0;
      cur = rec(0, 0, SX, SY, 0, 0, 0, 0);
      started = 1;
    end else begin
      if (q.size() != 0) begin
        if (move_pulses != 0 && !mwon && mdrop < 255)
          mdrop++;
      end else if (!mwon) begin
        plan(move_pulses);
      end
      if (q.size() != 0) begin
        cur = q.pop_front();
        mx = cur.x; my = cur.y; mwon = cur.won;
      end else begin
        cur = rec(0, 0, mx, my, 0, 0, 0, mwon);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (map_rd !== cur.rd || x_pos !== cur.x
          || y_pos !== cur.y || busy !== cur.busy
          || blocked !== cur.blk || fell !== cur.fell
          || won !== cur.won || drop_cnt !== mdrop[7:0]
          || (cur.rd && map_addr !== cur.addr)) begin
        miscompares++;
        $display("FAIL model t=%0t dut rd=%b a=%h p=(%0d,%0d) bz=%b bl=%b f=%b w=%b d=%0d exp rd=%b a=%h p=(%0d,%0d) bz=%b bl=%b f=%b w=%b d=%0d",
          $time, map_rd, map_addr, x_pos, y_pos, busy,
          blocked, fell, won, drop_cnt, cur.rd, cur.addr,
          cur.x, cur.y, cur.busy, cur.blk, cur.fell,
          cur.won, mdrop);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic pulse_go(input logic [3:0] p);
    @(negedge clk);
    move_pulses = p;
    @(negedge clk);
    move_pulses = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {7'd0, busy}, 8'd0);
  endtask

  task automatic move_to(input int tx, input int ty);
    for (int i = 0; i < 40; i++) begin
      if (mx == tx && my == ty) break;
      if (mx < tx) pulse_go(4'b1000);
      else if (mx > tx) pulse_go(4'b0100);
      else if (my < ty) pulse_go(4'b0010);
      else pulse_go(4'b0001);
      wait_idle();
    end
    chk("move_to", {x_pos, y_pos}, {tx[3:0], ty[3:0]});
  endtask

  int wc;
  logic [3:0] r4;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = CELL_OPEN;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_x", {4'd0, x_pos}, 8'd1);
    chk("rst_y", {4'd0, y_pos}, 8'd2);
    chk("rst_addr", map_addr, 8'h00);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_flags", {4'd0, map_rd, busy, won, fell}, 8'd0);

    // open move
    move_to(3, 3);
    pulse_go(4'b1000);
    chk("open_rd", {7'd0, map_rd}, 8'd1);
    chk("open_addr", map_addr, 8'h34);
    @(negedge clk);
    @(negedge clk);
    chk("open_pos", {x_pos, y_pos}, 8'h43);
    chk("open_busy", {7'd0, busy}, 8'd0);

    // grid edge, then wall
    move_to(15, 0);
    pulse_go(4'b1000);
    chk("edge_rd", {7'd0, map_rd}, 8'd0);
    @(negedge clk);
    chk("edge_blk", {7'd0, blocked}, 8'd1);
    @(negedge clk);
    chk("edge_pos", {x_pos, y_pos}, 8'hF0);
    mem[8'h1F] = CELL_WALL;
    pulse_go(4'b0010);
    chk("wall_addr", {map_rd, map_addr[6:0]}, 8'h9F);
    @(negedge clk);
    @(negedge clk);
    chk("wall_blk", {7'd0, blocked}, 8'd1);
    chk("wall_pos", {x_pos, y_pos}, 8'hF0);
    mem[8'h1F] = CELL_OPEN;
    wait_idle();

    // diagonal into a hole
    move_to(5, 5);
    mem[8'h66] = CELL_HOLE;
    pulse_go(4'b1010);
    chk("diag_a1", {7'd0, map_rd}, 8'd1);
    chk("diag_a1v", map_addr, 8'h56);
    @(negedge clk);
    @(negedge clk);
    chk("diag_a2", {7'd0, map_rd}, 8'd1);
    chk("diag_a2v", map_addr, 8'h66);
    chk("diag_mid", {x_pos, y_pos}, 8'h65);
    @(negedge clk);
    @(negedge clk);
    chk("hole_pos", {x_pos, y_pos}, {SX, SY});
    chk("hole_fell", {7'd0, fell}, 8'd1);
    @(negedge clk);
    chk("hole_fell_off", {7'd0, fell}, 8'd0);
    mem[8'h66] = CELL_OPEN;

    // cancelling pulses, then drop saturation
    pulse_go(4'b1100);
    chk("cancel", {6'd0, map_rd, busy}, 8'd0);
    for (int i = 0; i < 150; i++) begin
      pulse_go(i % 2 == 0 ? 4'b0001 : 4'b0010);
      move_pulses = 4'b1100;
      @(negedge clk);
      @(negedge clk);
      move_pulses = '0;
      wait_idle();
    end
    chk("drop_sat", drop_cnt, 8'd255);
    chk("drop_pos", {x_pos, y_pos}, {SX, SY});

    // reset during the check cycle, hole data ignored
    mem[8'h22] = CELL_HOLE;
    pulse_go(4'b1000);
    chk("mid_rd", {map_rd, map_addr[6:0]}, 8'hA2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_pos", {x_pos, y_pos}, {SX, SY});
    chk("mid_flags", {3'd0, map_rd, busy, blocked, fell, won}, 8'd0);
    chk("mid_drop", drop_cnt, 8'd0);
    chk("mid_addr", map_addr, 8'h00);
    mem[8'h22] = CELL_GOAL;

    // goal reached, further pulses ignored
    pulse_go(4'b1000);
    chk("goal_rd", {7'd0, map_rd}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    chk("goal_won", {7'd0, won}, 8'd1);
    chk("goal_pos", {x_pos, y_pos}, 8'h22);
    pulse_go(4'b0010);
    chk("won_nord", {6'd0, map_rd, busy}, 8'd0);
    @(negedge clk);
    chk("won_drop", drop_cnt, 8'd0);
    chk("won_pos", {x_pos, y_pos}, 8'h22);
    mem[8'h22] = CELL_OPEN;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // random map and random pulse traffic
    for (int i = 0; i < 256; i++) begin
      int c;
      c = $urandom_range(0, 99);
      if (c < 70) mem[i] = CELL_OPEN;
      else if (c < 85) mem[i] = CELL_WALL;
      else if (c < 95) mem[i] = CELL_HOLE;
      else mem[i] = CELL_GOAL;
    end
    wc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wc = mwon ? wc + 1 : 0;
      reset = ($urandom_range(0, 399) == 0) || wc > 12;
      r4 = 4'($urandom);
      move_pulses = ($urandom_range(0, 2) == 0) ? r4 : 4'd0;
    end
    @(negedge clk);
    move_pulses = '0;
    reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
